// File: rtl/execute_stage.sv
// EX stage: ALU, NZCV status register and EX/MEM output register.
// Define EXE_MUL_EN to build the iterative multiplier (MUL_BUSY/MUL_DONE states).
module execute_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic              valid_in,
  input  logic [3:0]        exe_cmd,
  input  logic              s_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  input  logic [3:0]        dest_in,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [DATA_W-1:0] st_val_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val_out,
  output logic [3:0]        dest_out,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en,
  output logic [3:0]        nzcv
);

  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;
  localparam logic [3:0] CmdMul = 4'b1010;

  typedef enum logic [1:0] {StIdle, StMulBusy, StMulDone} state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] st_val_q, st_val_d;
  logic [3:0]        dest_q, dest_d;
  logic              mem_r_q, mem_r_d;
  logic              mem_w_q, mem_w_d;
  logic              wb_q, wb_d;
  logic [3:0]        nzcv_q, nzcv_d;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   add_sum;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic              is_arith;
  logic              is_logic;
  logic [DATA_W-1:0] alu_res;
  logic              alu_v;
  logic              alu_upd;
  logic [3:0]        alu_flags;

  always_comb begin
    add_b    = val2;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    is_logic = 1'b0;
    alu_res  = '0;
    case (exe_cmd)
      CmdMov: begin alu_res = val2;        is_logic = 1'b1; end
      CmdMvn: begin alu_res = ~val2;       is_logic = 1'b1; end
      CmdAnd: begin alu_res = val1 & val2; is_logic = 1'b1; end
      CmdOrr: begin alu_res = val1 | val2; is_logic = 1'b1; end
      CmdEor: begin alu_res = val1 ^ val2; is_logic = 1'b1; end
      CmdAdd: is_arith = 1'b1;
      CmdAdc: begin is_arith = 1'b1; add_cin = nzcv_q[1]; end
      // Subtract as val1 + ~val2 + cin so carry-out is NOT borrow.
      CmdSub: begin is_arith = 1'b1; add_b = ~val2; add_cin = 1'b1; end
      CmdSbc: begin is_arith = 1'b1; add_b = ~val2; add_cin = nzcv_q[1]; end
      default: ;
    endcase
    add_sum = {1'b0, val1} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
    if (is_arith) alu_res = add_sum[DATA_W-1:0];
  end

  assign alu_v = (val1[DATA_W-1] == add_b[DATA_W-1]) &&
                 (add_sum[DATA_W-1] != val1[DATA_W-1]);

  // Undefined opcodes leave the flags untouched.
  always_comb begin
    alu_upd   = is_arith | is_logic;
    alu_flags = nzcv_q;
    if (is_arith) begin
      alu_flags = {alu_res[DATA_W-1], alu_res == '0, add_sum[DATA_W], alu_v};
    end else if (is_logic) begin
      alu_flags = {alu_res[DATA_W-1], alu_res == '0, nzcv_q[1:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Iterative multiplier
  // ---------------------------------------------------------------------------
  logic              mul_start;
  logic              mul_commit;
  logic [DATA_W-1:0] mul_prod;
  logic              mul_s;
  logic              mul_mr;
  logic              mul_mw;
  logic              mul_wb;
  logic [3:0]        mul_dest;
  logic [DATA_W-1:0] mul_st;

`ifdef EXE_MUL_EN
  localparam int unsigned MulSteps = DATA_W / MUL_STEP;
  localparam int unsigned CntW     = (MulSteps > 1) ? $clog2(MulSteps) : 1;

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              m_s_q, m_s_d;
  logic              m_mr_q, m_mr_d;
  logic              m_mw_q, m_mw_d;
  logic              m_wb_q, m_wb_d;
  logic [3:0]        m_dest_q, m_dest_d;
  logic [DATA_W-1:0] m_st_q, m_st_d;
  logic [DATA_W-1:0] step_sum;
  logic [DATA_W-1:0] pp_a;
  logic [DATA_W-1:0] pp_b;
  logic              mul_last;

  assign mul_start = (exe_cmd == CmdMul);
  assign mul_last  = (cnt_q == CntW'(MulSteps - 1));
  assign mul_s     = m_s_q;
  assign mul_mr    = m_mr_q;
  assign mul_mw    = m_mw_q;
  assign mul_wb    = m_wb_q;
  assign mul_dest  = m_dest_q;
  assign mul_st    = m_st_q;

  // Retire MUL_STEP multiplier bits into the accumulator.
  always_comb begin
    step_sum = acc_q;
    pp_a     = mcand_q;
    pp_b     = mplier_q;
    for (int unsigned j = 0; j < MUL_STEP; j++) begin
      if (pp_b[0]) step_sum = step_sum + pp_a;
      pp_a = pp_a << 1;
      pp_b = pp_b >> 1;
    end
  end
`else
  logic unused_mul_step;

  assign unused_mul_step = (MUL_STEP == 0);
  assign mul_start = 1'b0;
  assign mul_s     = 1'b0;
  assign mul_mr    = 1'b0;
  assign mul_mw    = 1'b0;
  assign mul_wb    = 1'b0;
  assign mul_dest  = '0;
  assign mul_st    = '0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    result_d   = result_q;
    st_val_d   = st_val_q;
    dest_d     = dest_q;
    mem_r_d    = mem_r_q;
    mem_w_d    = mem_w_q;
    wb_d       = wb_q;
    nzcv_d     = nzcv_q;
    mul_commit = 1'b0;
    mul_prod   = '0;
`ifdef EXE_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    m_s_d    = m_s_q;
    m_mr_d   = m_mr_q;
    m_mw_d   = m_mw_q;
    m_wb_d   = m_wb_q;
    m_dest_d = m_dest_q;
    m_st_d   = m_st_q;
`endif

    case (state_q)
      StIdle: begin
        if (!mem_stall) begin
          // Bubble unless a live instruction completes this edge.
          valid_d  = 1'b0;
          result_d = '0;
          st_val_d = '0;
          dest_d   = '0;
          mem_r_d  = 1'b0;
          mem_w_d  = 1'b0;
          wb_d     = 1'b0;
          if (valid_in && !flush && mul_start) begin
`ifdef EXE_MUL_EN
            state_d  = StMulBusy;
            mcand_d  = val1;
            mplier_d = val2;
            acc_d    = '0;
            cnt_d    = '0;
            m_s_d    = s_in;
            m_mr_d   = mem_r_en_in;
            m_mw_d   = mem_w_en_in;
            m_wb_d   = wb_en_in;
            m_dest_d = dest_in;
            m_st_d   = st_val_in;
`endif
          end else if (valid_in && !flush) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            st_val_d = st_val_in;
            dest_d   = dest_in;
            mem_r_d  = mem_r_en_in;
            mem_w_d  = mem_w_en_in;
            // Without the multiplier a MUL must not write back its zero result.
            wb_d     = wb_en_in && (exe_cmd != CmdMul);
            if (s_in && alu_upd) nzcv_d = alu_flags;
          end
        end
      end
`ifdef EXE_MUL_EN
      StMulBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          mcand_d  = mcand_q << MUL_STEP;
          mplier_d = mplier_q >> MUL_STEP;
          acc_d    = step_sum;
          cnt_d    = cnt_q + 1'b1;
          if (mul_last) begin
            if (mem_stall) begin
              state_d = StMulDone;
            end else begin
              state_d    = StIdle;
              mul_commit = 1'b1;
              mul_prod   = step_sum;
            end
          end
        end
      end
      StMulDone: begin
        if (flush) begin
          state_d = StIdle;
        end else if (!mem_stall) begin
          state_d    = StIdle;
          mul_commit = 1'b1;
          mul_prod   = acc_q;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (mul_commit) begin
      valid_d  = 1'b1;
      result_d = mul_prod;
      st_val_d = mul_st;
      dest_d   = mul_dest;
      mem_r_d  = mul_mr;
      mem_w_d  = mul_mw;
      wb_d     = mul_wb;
      if (mul_s) nzcv_d = {mul_prod[DATA_W-1], mul_prod == '0, nzcv_q[1:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      result_q <= '0;
      st_val_q <= '0;
      dest_q   <= '0;
      mem_r_q  <= 1'b0;
      mem_w_q  <= 1'b0;
      wb_q     <= 1'b0;
      nzcv_q   <= '0;
`ifdef EXE_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      m_s_q    <= 1'b0;
      m_mr_q   <= 1'b0;
      m_mw_q   <= 1'b0;
      m_wb_q   <= 1'b0;
      m_dest_q <= '0;
      m_st_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      st_val_q <= st_val_d;
      dest_q   <= dest_d;
      mem_r_q  <= mem_r_d;
      mem_w_q  <= mem_w_d;
      wb_q     <= wb_d;
      nzcv_q   <= nzcv_d;
`ifdef EXE_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      m_s_q    <= m_s_d;
      m_mr_q   <= m_mr_d;
      m_mw_q   <= m_mw_d;
      m_wb_q   <= m_wb_d;
      m_dest_q <= m_dest_d;
      m_st_q   <= m_st_d;
`endif
    end
  end

  assign ready_out  = (state_q == StIdle) && !mem_stall;
  assign valid_out  = valid_q;
  assign alu_result = result_q;
  assign st_val_out = st_val_q;
  assign dest_out   = dest_q;
  assign mem_r_en   = mem_r_q;
  assign mem_w_en   = mem_w_q;
  assign wb_en      = wb_q;
  assign nzcv       = nzcv_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage; multiplier scenarios build under EXE_MUL_EN.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        mem_stall;
  logic        valid_in;
  logic [3:0]  exe_cmd;
  logic        s_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        wb_en_in;
  logic [3:0]  dest_in;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] st_val_in;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] alu_result;
  logic [31:0] st_val_out;
  logic [3:0]  dest_out;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        wb_en;
  logic [3:0]  nzcv;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .mem_stall  (mem_stall),
    .valid_in   (valid_in),
    .exe_cmd    (exe_cmd),
    .s_in       (s_in),
    .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in),
    .wb_en_in   (wb_en_in),
    .dest_in    (dest_in),
    .val1       (val1),
    .val2       (val2),
    .st_val_in  (st_val_in),
    .ready_out  (ready_out),
    .valid_out  (valid_out),
    .alu_result (alu_result),
    .st_val_out (st_val_out),
    .dest_out   (dest_out),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .wb_en      (wb_en),
    .nzcv       (nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in    = 1'b0;
    exe_cmd     = 4'h0;
    s_in        = 1'b0;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    wb_en_in    = 1'b0;
    dest_in     = 4'h0;
    val1        = '0;
    val2        = '0;
    st_val_in   = '0;
  endtask

  task automatic op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                    input logic s, input logic [3:0] d);
    valid_in    = 1'b1;
    exe_cmd     = cmd;
    s_in        = s;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    wb_en_in    = 1'b1;
    dest_in     = d;
    val1        = a;
    val2        = b;
    st_val_in   = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", alu_result); end
    checks++; if (nzcv !== 4'b0000) begin errors++; $display("FAIL reset_nzcv: got %b want 0000", nzcv); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_out); end
    checks++; if ({wb_en, mem_r_en, mem_w_en, dest_out} !== 7'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", {wb_en, mem_r_en, mem_w_en, dest_out}); end
  endtask

  task automatic test_add_flags();
    op(4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b1, 4'd3);
    tick();
    checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL add_wrap_result: got %h want 0", alu_result); end
    checks++; if (nzcv !== 4'b0110) begin errors++; $display("FAIL add_wrap_nzcv: got %b want 0110", nzcv); end
    checks++; if ({valid_out, wb_en, dest_out} !== 6'b11_0011) begin errors++; $display("FAIL add_ctrl: got %b want 110011", {valid_out, wb_en, dest_out}); end
    checks++; if (st_val_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL add_stval: got %h want deadbeef", st_val_out); end
    op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, 4'd3);
    tick();
    checks++; if ({alu_result, nzcv} !== {32'h8000_0000, 4'b1001}) begin errors++; $display("FAIL add_ovf: got %h/%b want 80000000/1001", alu_result, nzcv); end
  endtask

  task automatic test_sub_sbc();
    op(4'b0100, 32'd5, 32'd7, 1'b1, 4'd1);
    tick();
    checks++; if ({alu_result, nzcv} !== {32'hFFFF_FFFE, 4'b1000}) begin errors++; $display("FAIL sub: got %h/%b want fffffffe/1000", alu_result, nzcv); end
    op(4'b0101, 32'd10, 32'd3, 1'b1, 4'd2);
    tick();
    checks++; if ({alu_result, nzcv} !== {32'd6, 4'b0010}) begin errors++; $display("FAIL sbc: got %h/%b want 00000006/0010", alu_result, nzcv); end
  endtask

  task automatic test_logic();
    op(4'b0110, 32'hF0F0_0000, 32'hFFFF_0000, 1'b1, 4'd4);
    tick();
    checks++; if ({alu_result, nzcv} !== {32'hF0F0_0000, 4'b1010}) begin errors++; $display("FAIL and: got %h/%b want f0f00000/1010", alu_result, nzcv); end
    op(4'b1000, 32'h5, 32'h5, 1'b0, 4'd4);
    tick();
    checks++; if ({alu_result, nzcv} !== {32'h0, 4'b1010}) begin errors++; $display("FAIL eor_nos: got %h/%b want 00000000/1010", alu_result, nzcv); end
    op(4'b1001, 32'h0, 32'h0000_00FF, 1'b1, 4'd4);
    tick();
    checks++; if ({alu_result, nzcv} !== {32'hFFFF_FF00, 4'b1010}) begin errors++; $display("FAIL mvn: got %h/%b want ffffff00/1010", alu_result, nzcv); end
  endtask

  task automatic test_bubble_flush();
    idle();
    tick();
    checks++; if ({valid_out, wb_en} !== 2'b00) begin errors++; $display("FAIL bubble: got %b want 00", {valid_out, wb_en}); end
    op(4'b0010, 32'd2, 32'd3, 1'b1, 4'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({valid_out, wb_en, nzcv} !== 6'b00_1010) begin errors++; $display("FAIL idle_flush: got %b want 001010", {valid_out, wb_en, nzcv}); end
  endtask

  task automatic test_stall();
    op(4'b0010, 32'd2, 32'd3, 1'b0, 4'd5);
    tick();
    checks++; if ({valid_out, alu_result} !== {1'b1, 32'd5}) begin errors++; $display("FAIL stall_pre: got %b/%h want 1/5", valid_out, alu_result); end
    mem_stall = 1'b1;
    op(4'b0100, 32'd9, 32'd1, 1'b0, 4'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({alu_result, dest_out, wb_en, ready_out} !== {32'd5, 4'd5, 1'b1, 1'b0}) begin errors++; $display("FAIL stall_hold%0d: got %h/%h/%b/%b want 5/5/1/0", i, alu_result, dest_out, wb_en, ready_out); end
    end
    mem_stall = 1'b0;
    tick();
    idle();
    checks++; if ({valid_out, alu_result, dest_out} !== {1'b1, 32'd8, 4'd6}) begin errors++; $display("FAIL stall_release: got %b/%h/%h want 1/8/6", valid_out, alu_result, dest_out); end
  endtask

`ifdef EXE_MUL_EN
  task automatic test_mul();
    int n;
    op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, 4'd3);
    tick();
    op(4'b1010, 32'h1234, 32'h10, 1'b0, 4'd7);
    tick();
    idle();
    checks++; if ({ready_out, valid_out} !== 2'b00) begin errors++; $display("FAIL mul_accept: got %b want 00", {ready_out, valid_out}); end
    n = 0;
    while (!ready_out && n < 40) begin tick(); n++; end
    checks++; if (n !== 32) begin errors++; $display("FAIL mul_latency: got %0d want 32", n); end
    checks++; if ({valid_out, alu_result, wb_en, dest_out} !== {1'b1, 32'h12340, 1'b1, 4'd7}) begin errors++; $display("FAIL mul_result: got %b/%h/%b/%h want 1/12340/1/7", valid_out, alu_result, wb_en, dest_out); end
    checks++; if (nzcv !== 4'b1001) begin errors++; $display("FAIL mul_nzcv: got %b want 1001", nzcv); end
  endtask

  task automatic test_mul_flush();
    op(4'b1010, 32'h3, 32'h5, 1'b1, 4'd7);
    tick();
    idle();
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({ready_out, valid_out, nzcv} !== 6'b10_1001) begin errors++; $display("FAIL mul_flush: got %b want 101001", {ready_out, valid_out, nzcv}); end
    op(4'b0010, 32'd2, 32'd3, 1'b0, 4'd5);
    tick();
    idle();
    checks++; if ({valid_out, alu_result} !== {1'b1, 32'd5}) begin errors++; $display("FAIL mul_flush_next: got %b/%h want 1/5", valid_out, alu_result); end
    for (int i = 0; i < 35; i++) tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mul_flush_ghost: got %b want 0", valid_out); end
  endtask

  task automatic test_mul_stall_done();
    op(4'b1010, 32'h3, 32'h5, 1'b1, 4'd8);
    tick();
    idle();
    mem_stall = 1'b1;
    for (int i = 0; i < 35; i++) tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mul_done_hold: got %b want 0", valid_out); end
    mem_stall = 1'b0;
    #1;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL mul_done_ready: got %b want 0", ready_out); end
    tick();
    checks++; if ({valid_out, alu_result, nzcv, ready_out} !== {1'b1, 32'd15, 4'b0001, 1'b1}) begin errors++; $display("FAIL mul_done_load: got %b/%h/%b/%b want 1/f/0001/1", valid_out, alu_result, nzcv, ready_out); end
  endtask

  task automatic test_reset_mid_mul();
    op(4'b1010, 32'h3, 32'h5, 1'b1, 4'd8);
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({ready_out, valid_out, alu_result, nzcv} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin errors++; $display("FAIL reset_mid_mul: got %b/%b/%h/%b want 1/0/0/0000", ready_out, valid_out, alu_result, nzcv); end
    for (int i = 0; i < 35; i++) tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_mul_ghost: got %b want 0", valid_out); end
  endtask
`else
  task automatic test_mul_disabled();
    op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, 4'd3);
    tick();
    op(4'b1010, 32'h1234, 32'h10, 1'b1, 4'd7);
    #1;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL nomul_ready: got %b want 1", ready_out); end
    tick();
    idle();
    checks++; if ({valid_out, alu_result, wb_en, dest_out} !== {1'b1, 32'h0, 1'b0, 4'd7}) begin errors++; $display("FAIL nomul_result: got %b/%h/%b/%h want 1/0/0/7", valid_out, alu_result, wb_en, dest_out); end
    checks++; if (nzcv !== 4'b1001) begin errors++; $display("FAIL nomul_nzcv: got %b want 1001", nzcv); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({valid_out, nzcv, ready_out} !== {1'b0, 4'h0, 1'b1}) begin errors++; $display("FAIL nomul_reset: got %b/%b/%b want 0/0000/1", valid_out, nzcv, ready_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_flags();
    test_sub_sbc();
    test_logic();
    test_bubble_flush();
    test_stall();
`ifdef EXE_MUL_EN
    test_mul();
    test_mul_flush();
    test_mul_stall_done();
    test_reset_mid_mul();
`else
    test_mul_disabled();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage core. Sits directly downstream of the ID/EX pipeline register.
- Consumes its control bits (EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, dest) and operands (val1, val2, store data).
- Computes the ALU result, maintains the NZCV status register, and drives the EX/MEM register from its own output flops.
- Contains a multi-cycle iterative multiplier FSM that back-pressures the front end via ready_out.

Parameters:
- DATA_W, 32, operand/result width; must be a multiple of MUL_STEP.
- MUL_STEP, 1, multiplier bits retired per cycle; multiply latency N = DATA_W/MUL_STEP cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  branch-taken squash of the incoming or in-flight instruction.
- mem_stall  in  1  downstream hold; output register frozen.
- valid_in  in  1  ID/EX slot holds a real instruction.
- exe_cmd  in  4  ALU op.
- s_in  in  1  update NZCV.
- mem_r_en_in, mem_w_en_in, wb_en_in  in  1 each  control passthrough.
- dest_in  in  4  destination register.
- val1, val2  in  DATA_W  operands.
- st_val_in  in  DATA_W  store data.
- ready_out  out  1  stage can accept; = (state==IDLE) && !mem_stall.
- valid_out  out  1  EX/MEM slot valid.
- alu_result  out  DATA_W  result / memory address.
- st_val_out  out  DATA_W  registered store data.
- dest_out  out  4  registered dest.
- mem_r_en, mem_w_en, wb_en  out  1 each  registered control; forced 0 when the slot is invalid.
- nzcv  out  4  status register {N,Z,C,V}.

Behaviour:
- Reset: all outputs 0 except ready_out=1. nzcv=0, FSM=IDLE, multiplier datapath cleared. Reset mid-multiply aborts it.
- exe_cmd encoding:
  - 0001 MOV=val2; 1001 MVN=~val2.
  - 0010 ADD; 0011 ADC=val1+val2+C.
  - 0100 SUB=val1-val2; 0101 SBC=val1-val2-!C.
  - 0110 AND; 0111 ORR; 1000 EOR.
  - 1010 MUL = low DATA_W bits of val1*val2.
  - All other codes: result 0.
- Arithmetic: add/sub use a DATA_W+1 bit sum. C = carry-out; for SUB/SBC, C = NOT borrow (C=1 when val1>=val2 for SUB). V = signed overflow. N = result[DATA_W-1]. Z = (result==0).
- Flags for logic/MOV/MVN: only N,Z are updated; C,V are kept. MUL: only N,Z are updated.
- Flags commit only when s_in=1, the instruction is valid, not flushed, and its result loads into the output register (same edge).
- Single-cycle ops: on a clk edge with ready_out=1, valid_in=1, !flush, the output register loads result and controls. Latency 1.
- FSM, states IDLE, MUL_BUSY, MUL_DONE:
  - IDLE -> MUL_BUSY: exe_cmd=1010 accepted at edge E. Operands and controls latched; valid_out/enables load 0 (bubble) at E.
  - MUL_BUSY: one shift-add step of MUL_STEP bits per edge. After step N, the product is complete.
  - Completion, mem_stall=0: at edge E+N the output register loads the product and controls, and the FSM goes to IDLE.
  - Completion, mem_stall=1: FSM goes to MUL_DONE and holds the product; it loads at the first edge with mem_stall=0, then IDLE.
- mem_stall=1: output register and nzcv hold; an incoming instruction is not accepted (ready_out=0). MUL_BUSY iteration continues.
- flush=1:
  - IDLE: the incoming instruction is discarded, the output register loads a bubble (if !mem_stall), flags unchanged.
  - MUL_BUSY or MUL_DONE: the multiply is aborted to IDLE; no result and no flag commit.
  - A flush never alters a slot already in the output register.
- Priority: rst > flush > mem_stall > normal.
- valid_in=0: treated as a bubble; output loads all-zero controls, valid_out=0.

Optional Feature:
- Macro EXE_MUL_EN.
- Defined: iterative multiplier and MUL_BUSY/MUL_DONE states as above.
- Undefined: no multiplier logic and FSM fixed at IDLE. Cmd 1010 executes in one cycle with result 0, wb_en forced 0, flags unchanged. ready_out = !mem_stall.

Test Plan:
- ADD val1=0xFFFFFFFF, val2=1, s_in=1 -> next cycle alu_result=0, nzcv=0110.
- SUB val1=5, val2=7, s_in=1 -> 0xFFFFFFFE, nzcv=1000. Then SBC 10-3 (C=0) -> 6.
- MUL 0x1234*0x10 at edge E (MUL_STEP=1) -> ready_out low for 32 cycles; alu_result=0x12340 and valid_out=1 after edge E+32; nzcv unchanged when s_in=0.
- MUL accepted, flush at cycle 10 -> FSM IDLE, valid_out stays 0, nzcv unchanged. The next ADD 2+3 produces 5 one cycle after acceptance.
- mem_stall held 3 cycles while valid_out=1 (ADD result 5) -> alu_result/dest_out/wb_en constant, ready_out=0. Release -> the queued instruction completes next cycle.
- rst asserted mid-multiply -> all outputs 0, ready_out=1 after the reset edge, nzcv=0.
